// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-bus request at a
// time and fills the fetch/decode pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        ireq_data_ok,
   input  logic [31:0] ireq_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        fd_valid,
   output logic [31:0] fd_instruction,
   output logic [31:0] fd_pc_plus_4,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DISCARD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] disc_addr_q, disc_addr_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc4_q, hold_pc4_d;
   logic        fd_valid_q, fd_valid_d;
   logic [31:0] fd_instr_q, fd_instr_d;
   logic [31:0] fd_pc4_q, fd_pc4_d;

   logic        redirect;
   logic [31:0] new_pc;
   logic [31:0] pc_addr;
   logic [31:0] pc_plus_4;

   // Branch comes from an older instruction than jump, so it takes precedence.
   assign redirect  = branch_taken | jump;
   assign new_pc    = branch_taken ? {branch_target[31:2], 2'b00}
                                   : {jump_target[31:2], 2'b00};
   assign pc_addr   = {pc_q[31:2], 2'b00};
   assign pc_plus_4 = pc_addr + 32'd4;

   // While discarding, the bus must keep seeing the abandoned address even
   // though pc already holds the redirect target.
   assign ireq_addr  = (state_q == DISCARD) ? disc_addr_q : pc_addr;
   assign ireq_valid = reset && ((state_q == FETCH) || (state_q == DISCARD));
   assign fetch_busy = (state_q != FETCH) || !ireq_data_ok;

   assign fd_valid       = fd_valid_q;
   assign fd_instruction = fd_instr_q;
   assign fd_pc_plus_4   = fd_pc4_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      disc_addr_d  = disc_addr_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      fd_valid_d   = fd_valid_q;
      fd_instr_d   = fd_instr_q;
      fd_pc4_d     = fd_pc4_q;

      case (state_q)
         FETCH: begin
            if (ireq_data_ok) begin
               if (redirect) begin
                  pc_d = new_pc;
               end else if (!stall) begin
                  fd_valid_d = 1'b1;
                  fd_instr_d = ireq_data;
                  fd_pc4_d   = pc_plus_4;
                  pc_d       = pc_plus_4;
               end else begin
                  hold_instr_d = ireq_data;
                  hold_pc4_d   = pc_plus_4;
                  pc_d         = pc_plus_4;
                  state_d      = HOLD;
               end
            end else if (redirect) begin
               pc_d        = new_pc;
               disc_addr_d = pc_addr;
               state_d     = DISCARD;
            end else if (!stall) begin
               fd_valid_d = 1'b0;
               fd_instr_d = '0;
               fd_pc4_d   = '0;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = new_pc;
               state_d = FETCH;
            end else if (!stall) begin
               fd_valid_d = 1'b1;
               fd_instr_d = hold_instr_q;
               fd_pc4_d   = hold_pc4_q;
               state_d    = FETCH;
            end
         end
         DISCARD: begin
            if (redirect) begin
               pc_d = new_pc;
            end
            if (ireq_data_ok) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (flush) begin
         fd_valid_d = 1'b0;
         fd_instr_d = '0;
         fd_pc4_d   = '0;
      end else if (stall) begin
         fd_valid_d = fd_valid_q;
         fd_instr_d = fd_instr_q;
         fd_pc4_d   = fd_pc4_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         disc_addr_q  <= '0;
         hold_instr_q <= '0;
         hold_pc4_q   <= '0;
         fd_valid_q   <= 1'b0;
         fd_instr_q   <= '0;
         fd_pc4_q     <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         disc_addr_q  <= disc_addr_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         fd_valid_q   <= fd_valid_d;
         fd_instr_q   <= fd_instr_d;
         fd_pc4_q     <= fd_pc4_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one table row per clock cycle, plus a
// multi-cycle bus-latency sequence.
module tb_fetch_stage;

   localparam logic [31:0] R  = 32'h8000_0000;
   localparam logic [31:0] I0 = 32'h1111_0001;
   localparam logic [31:0] I1 = 32'h2222_0002;
   localparam logic [31:0] IS = 32'h2108_0001;
   localparam logic [31:0] I2 = 32'h3333_0003;
   localparam logic [31:0] I3 = 32'h4444_0004;
   localparam logic [31:0] I4 = 32'h7777_0007;
   localparam logic [31:0] I5 = 32'h8888_0008;
   localparam logic [31:0] I6 = 32'h9999_0009;
   localparam logic [31:0] I7 = 32'hAAAA_000A;
   localparam logic [31:0] I8 = 32'hBBBB_000B;
   localparam logic [31:0] I9 = 32'hCCCC_000C;
   localparam int unsigned NV = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        ireq_data_ok;
   logic [31:0] ireq_data;
   logic        stall, flush, jump, branch_taken;
   logic [31:0] jump_target, branch_target;
   logic        fd_valid;
   logic [31:0] fd_instruction, fd_pc_plus_4;
   logic        fetch_busy;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage #(.RESET_PC(R)) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .ireq_data_ok  (ireq_data_ok),
      .ireq_data     (ireq_data),
      .stall         (stall),
      .flush         (flush),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .fd_valid      (fd_valid),
      .fd_instruction(fd_instruction),
      .fd_pc_plus_4  (fd_pc_plus_4),
      .fetch_busy    (fetch_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        dok;
      logic [31:0] data;
      logic        stl;
      logic        fls;
      logic        jmp;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic        e_valid;
      logic [31:0] e_addr;
      logic        e_fdv;
      logic [31:0] e_fdi;
      logic [31:0] e_fdp;
      logic        e_busy;
   } vec_t;

   vec_t tbl [NV];

   function automatic vec_t mk(
      input logic rst, input logic dok, input logic [31:0] data,
      input logic stl, input logic fls, input logic jmp, input logic [31:0] jt,
      input logic br, input logic [31:0] bt,
      input logic e_valid, input logic [31:0] e_addr, input logic e_fdv,
      input logic [31:0] e_fdi, input logic [31:0] e_fdp, input logic e_busy);
      vec_t v;
      v.rst = rst; v.dok = dok; v.data = data; v.stl = stl; v.fls = fls;
      v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt;
      v.e_valid = e_valid; v.e_addr = e_addr; v.e_fdv = e_fdv;
      v.e_fdi = e_fdi; v.e_fdp = e_fdp; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic dok, input logic [31:0] data,
                        input logic stl, input logic fls, input logic jmp,
                        input logic [31:0] jt, input logic br, input logic [31:0] bt);
      reset = rst; ireq_data_ok = dok; ireq_data = data; stall = stl; flush = fls;
      jump = jmp; jump_target = jt; branch_taken = br; branch_target = bt;
   endtask

   initial begin
      logic [31:0] exp_pc;

      tbl[0]  = mk(0, 0, 0,            0, 0, 0, 0,            0, 0,       0, R,            0, 0,  0,         1);
      tbl[1]  = mk(1, 1, I0,           0, 0, 0, 0,            0, 0,       1, R,            0, 0,  0,         0);
      tbl[2]  = mk(1, 1, I1,           0, 0, 0, 0,            0, 0,       1, R + 32'h4,    1, I0, R + 32'h4, 0);
      tbl[3]  = mk(1, 1, IS,           1, 0, 0, 0,            0, 0,       1, R + 32'h8,    1, I1, R + 32'h8, 0);
      tbl[4]  = mk(1, 0, 0,            1, 0, 0, 0,            0, 0,       0, R + 32'hC,    1, I1, R + 32'h8, 1);
      tbl[5]  = mk(1, 0, 0,            1, 0, 0, 0,            0, 0,       0, R + 32'hC,    1, I1, R + 32'h8, 1);
      tbl[6]  = mk(1, 0, 0,            0, 0, 0, 0,            0, 0,       0, R + 32'hC,    1, I1, R + 32'h8, 1);
      tbl[7]  = mk(1, 0, 0,            0, 0, 0, 0,            0, 0,       1, R + 32'hC,    1, IS, R + 32'hC, 1);
      tbl[8]  = mk(1, 0, 0,            0, 0, 1, R + 32'h100,  0, 0,       1, R + 32'hC,    0, 0,  0,         1);
      tbl[9]  = mk(1, 0, 0,            0, 0, 0, 0,            0, 0,       1, R + 32'hC,    0, 0,  0,         1);
      tbl[10] = mk(1, 1, 32'hDEADBEEF, 0, 0, 0, 0,            0, 0,       1, R + 32'hC,    0, 0,  0,         1);
      tbl[11] = mk(1, 1, I2,           0, 0, 0, 0,            0, 0,       1, R + 32'h100,  0, 0,  0,         0);
      tbl[12] = mk(1, 0, 0,            0, 0, 1, R + 32'h200,  1, R + 32'h40, 1, R + 32'h104, 1, I2, R + 32'h104, 1);
      tbl[13] = mk(1, 1, 32'h5555_5555, 0, 0, 0, 0,           0, 0,       1, R + 32'h104,  1, I2, R + 32'h104, 1);
      tbl[14] = mk(1, 0, 0,            1, 1, 0, 0,            0, 0,       1, R + 32'h40,   1, I2, R + 32'h104, 1);
      tbl[15] = mk(1, 0, 0,            0, 0, 0, 0,            0, 0,       1, R + 32'h40,   0, 0,  0,         1);
      tbl[16] = mk(1, 1, I3,           0, 0, 0, 0,            0, 0,       1, R + 32'h40,   0, 0,  0,         0);
      tbl[17] = mk(1, 1, 32'h6666_6666, 0, 0, 1, 32'hFFFF_FFFC, 0, 0,     1, R + 32'h44,   1, I3, R + 32'h44, 0);
      tbl[18] = mk(1, 1, I4,           0, 0, 0, 0,            0, 0,       1, 32'hFFFF_FFFC, 1, I3, R + 32'h44, 0);
      tbl[19] = mk(1, 1, I5,           0, 0, 1, R + 32'h13,   0, 0,       1, 0,            1, I4, 0,         0);
      tbl[20] = mk(1, 1, I6,           0, 0, 0, 0,            0, 0,       1, R + 32'h10,   1, I4, 0,         0);
      tbl[21] = mk(1, 1, I7,           1, 0, 0, 0,            0, 0,       1, R + 32'h14,   1, I6, R + 32'h14, 0);
      tbl[22] = mk(1, 0, 0,            1, 0, 1, R + 32'h300,  0, 0,       0, R + 32'h18,   1, I6, R + 32'h14, 1);
      tbl[23] = mk(1, 1, I8,           0, 0, 0, 0,            0, 0,       1, R + 32'h300,  1, I6, R + 32'h14, 0);
      tbl[24] = mk(1, 0, 0,            0, 0, 1, R + 32'h400,  0, 0,       1, R + 32'h304,  1, I8, R + 32'h304, 1);
      tbl[25] = mk(1, 0, 0,            0, 0, 0, 0,            1, R + 32'h500, 1, R + 32'h304, 1, I8, R + 32'h304, 1);
      tbl[26] = mk(1, 1, 32'hABCD_0000, 0, 0, 0, 0,           0, 0,       1, R + 32'h304,  1, I8, R + 32'h304, 1);
      tbl[27] = mk(1, 1, I9,           0, 0, 0, 0,            0, 0,       1, R + 32'h500,  1, I8, R + 32'h304, 0);
      tbl[28] = mk(0, 0, 0,            0, 0, 0, 0,            0, 0,       0, R + 32'h504,  1, I9, R + 32'h504, 1);
      tbl[29] = mk(1, 0, 0,            0, 0, 0, 0,            0, 0,       1, R,            0, 0,  0,         1);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;

      for (int i = 0; i < int'(NV); i++) begin
         drive(tbl[i].rst, tbl[i].dok, tbl[i].data, tbl[i].stl, tbl[i].fls,
               tbl[i].jmp, tbl[i].jt, tbl[i].br, tbl[i].bt);
         @(negedge clk);
         chk($sformatf("row%0d ireq_valid", i), {31'b0, ireq_valid}, {31'b0, tbl[i].e_valid});
         chk($sformatf("row%0d ireq_addr", i), ireq_addr, tbl[i].e_addr);
         chk($sformatf("row%0d fd_valid", i), {31'b0, fd_valid}, {31'b0, tbl[i].e_fdv});
         chk($sformatf("row%0d fd_instruction", i), fd_instruction, tbl[i].e_fdi);
         chk($sformatf("row%0d fd_pc_plus_4", i), fd_pc_plus_4, tbl[i].e_fdp);
         chk($sformatf("row%0d fetch_busy", i), {31'b0, fetch_busy}, {31'b0, tbl[i].e_busy});
         @(posedge clk); #1;
      end

      // Three-cycle bus: address must hold steady until data_ok.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      exp_pc = R;
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 2; w++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("lat k%0d w%0d ireq_valid", k, w), {31'b0, ireq_valid}, 32'd1);
            chk($sformatf("lat k%0d w%0d ireq_addr", k, w), ireq_addr, exp_pc);
            if (k > 0 && w == 0) begin
               chk($sformatf("lat k%0d fd_instruction", k), fd_instruction, 32'h0100_0000 + 32'(k - 1));
               chk($sformatf("lat k%0d fd_pc_plus_4", k), fd_pc_plus_4, exp_pc);
            end
            @(posedge clk); #1;
         end
         drive(1, 1, 32'h0100_0000 + 32'(k), 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("lat k%0d ack ireq_addr", k), ireq_addr, exp_pc);
         chk($sformatf("lat k%0d ack fetch_busy", k), {31'b0, fetch_busy}, 32'd0);
         @(posedge clk); #1;
         exp_pc = exp_pc + 32'd4;
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("lat final fd_valid", {31'b0, fd_valid}, 32'd1);
      chk("lat final fd_instruction", fd_instruction, 32'h0100_0002);
      chk("lat final fd_pc_plus_4", fd_pc_plus_4, R + 32'hC);
      chk("lat final ireq_addr", ireq_addr, R + 32'hC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. Owns the PC and issues one instruction-bus request at a time. Captures the returned word into the fetch/decode pipeline register (instruction, pc_plus_4). Honours stall/flush from the hazard unit and PC redirects from decode (jump) and memory (branch), including redirects that arrive while a bus request is still outstanding.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: sampled low at a rising edge resets the block.
- ireq_valid  out  1  instruction request valid; held until ireq_data_ok.
- ireq_addr  out  32  request address; stable while ireq_valid is high.
- ireq_data_ok  in  1  response strobe; ireq_data is valid in the same cycle.
- ireq_data  in  32  returned instruction word.
- stall  in  1  hazard unit: hold the f/d register.
- flush  in  1  hazard unit: replace the f/d contents with a bubble.
- jump  in  1  decode-stage J redirect.
- jump_target  in  32  target for jump.
- branch_taken  in  1  memory-stage BEQ resolved taken.
- branch_target  in  32  target for branch_taken.
- fd_valid  out  1  f/d register holds a real instruction.
- fd_instruction  out  32  f/d instruction; 0 (NOP) when not valid.
- fd_pc_plus_4  out  32  f/d PC+4.
- fetch_busy  out  1  high when state is not FETCH or no response arrived this cycle; informs the hazard unit.

## Operation
- Registers:
  - pc (32)
  - state: FETCH, HOLD, DISCARD
  - hold_instr, hold_pc4 (32 each)
  - fd_valid, fd_instruction, fd_pc_plus_4
- ireq_valid = reset && (state==FETCH || state==DISCARD). ireq_addr = {pc[31:2], 2'b00}.
- redirect = branch_taken || jump. new_pc = branch_taken ? branch_target : jump_target. Branch wins because it is the older instruction. Low two bits of new_pc are forced to 0.
- FETCH:
  - data_ok && redirect: drop the data; pc <= new_pc; stay in FETCH.
  - data_ok && !stall: f/d <= {1, ireq_data, pc+4}; pc <= pc+4.
  - data_ok && stall: hold <= {ireq_data, pc+4}; pc <= pc+4; go to HOLD.
  - !data_ok && redirect: pc <= new_pc; go to DISCARD.
  - !data_ok && !stall: f/d <= bubble {0, 0, 0}.
- HOLD (no request on the bus):
  - redirect: drop the buffer; pc <= new_pc; go to FETCH.
  - !stall: f/d <= {1, hold_instr, hold_pc4}; go to FETCH.
  - otherwise stay in HOLD.
- DISCARD (old request still outstanding):
  - Request stays at the old address until data_ok, then the data is dropped and the state goes to FETCH.
  - pc already holds the target, so ireq_addr switches on the cycle after data_ok.
  - A further redirect while in DISCARD overwrites pc and stays in DISCARD.
- Priority on the f/d register: reset > flush > stall > load/bubble. flush forces f/d to bubble even when stall is high. flush does not change pc, state or the hold buffer.
- Address arithmetic is mod 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - pc = RESET_PC, state = FETCH
  - fd_valid = 0, fd_instruction = 0, fd_pc_plus_4 = 0
  - hold registers = 0
  - ireq_valid = 0 while reset is low
- First request: ireq_valid = 1 with ireq_addr = RESET_PC in the first cycle after reset deasserts.
- Latency: data_ok in cycle N makes the instruction visible on fd_* in cycle N+1. The next request (pc+4) is issued in cycle N+1, so back-to-back fetch with a single-cycle bus gives one instruction per cycle.
- Bus rule: ireq_addr must not change while ireq_valid is high and data_ok has not arrived, including across redirects.
- Reset low mid-request: the block returns to its reset values. The bus slave must tolerate the abandoned request.
- fetch_busy is combinational from the current state and ireq_data_ok.

## Test plan
- Reset with a 1-cycle bus: after reset, ireq_addr shows 8000_0000, 8000_0004, 8000_0008 on consecutive cycles. fd_pc_plus_4 shows 8000_0004, 8000_0008 one cycle after each request. fd_valid = 1 from the second cycle.
- Stall for 3 cycles while data_ok returns 0x2108_0001: f/d holds its previous value and the state goes to HOLD with no request. When stall drops, f/d = 0x2108_0001 the next cycle and the next request goes to pc+4.
- Bus latency 4 with jump to 0x8000_0100 issued in the request's 2nd cycle: ireq_addr stays at the old PC until data_ok. The returned word never reaches f/d. The following request is 8000_0100.
- branch_taken to 0x8000_0040 and jump to 0x8000_0200 in the same cycle: the next fetch address is 8000_0040.
- flush and stall together in one cycle: f/d becomes {0, 0, 0} the next cycle; pc and state are unchanged.
- Jump target 0xFFFF_FFFC followed by a fetch: fd_pc_plus_4 = 0 and the next ireq_addr = 0. A jump target of 0x8000_0013 fetches from 8000_0010.
